// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  // MDU wait sequencer states
  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Stage hold / bubble controls
  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic flushD;
    logic flushE;
    logic flushM;
  } ctrl_t;

  // A producer hazards a consumer only when it writes a real register (x0 never hazards)
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational data-hazard detection for the instruction in decode.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic       branchD,
  input  logic [4:0] rdE,
  input  logic       regWriteE,
  input  logic       memToRegE,
  input  logic [4:0] rdM,
  input  logic       memToRegM,
  output logic       loadUse,
  output logic       branchAlu,
  output logic       branchLoadM
);

  // Load in E feeding decode, ALU result in E feeding a decode-stage compare,
  // and a load in M feeding a decode-stage compare (no M->D load bypass exists).
  always_comb begin
    loadUse     = memToRegE & regWriteE & reg_match(rdE, rs1D, rs2D);
    branchAlu   = branchD & regWriteE & ~memToRegE & reg_match(rdE, rs1D, rs2D);
    branchLoadM = branchD & memToRegM & reg_match(rdM, rs1D, rs2D);
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: data-hazard stalls, taken-branch flush, MDU wait FSM with
// watchdog, and a saturating stall-cycle counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             branchD,
  input  logic             pcSrcD,
  input  logic [4:0]       rdE,
  input  logic             regWriteE,
  input  logic             memToRegE,
  input  logic [4:0]       rdM,
  input  logic             memToRegM,
  input  logic             mduOpE,
  input  logic             mduDone,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             mduStart,
  output logic             mduError,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int unsigned WD_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

  state_t           state_q;
  logic [WD_W-1:0]  wd_cnt_q;
  logic             error_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic  load_use, branch_alu, branch_load_m;
  logic  mdu_timeout;
  ctrl_t ctrl;
  logic  start;

  hazard_detect u_detect (
    .rs1D        (rs1D),
    .rs2D        (rs2D),
    .branchD     (branchD),
    .rdE         (rdE),
    .regWriteE   (regWriteE),
    .memToRegE   (memToRegE),
    .rdM         (rdM),
    .memToRegM   (memToRegM),
    .loadUse     (load_use),
    .branchAlu   (branch_alu),
    .branchLoadM (branch_load_m)
  );

  // Stall/flush/start decode from current state and inputs; MDU wait outranks data hazards
  always_comb begin
    ctrl        = '0;
    start       = 1'b0;
    mdu_timeout = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (mduOpE) begin
            // Hold E with the MDU op and bubble M; flushE stays low since E is held
            start       = 1'b1;
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.stallE = 1'b1;
            ctrl.flushM = 1'b1;
          end else if (load_use | branch_alu | branch_load_m) begin
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.flushE = 1'b1;
          end
          // A taken branch is ignored while decode is held
          ctrl.flushD = pcSrcD & ~ctrl.stallD;
        end
        BUSY: begin
          if (mduDone) begin
            // Release: EX-MEM captures the MDU result on this edge
          end else if (wd_cnt_q == WD_LAST) begin
            mdu_timeout = 1'b1;
          end else begin
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.stallE = 1'b1;
            ctrl.flushM = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, watchdog, sticky error flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wd_cnt_q    <= '0;
      error_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mduOpE) begin
            state_q  <= BUSY;
            wd_cnt_q <= '0;
          end
        end
        BUSY: begin
          if (mduDone || mdu_timeout) begin
            state_q <= IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (mdu_timeout) begin
        error_q <= 1'b1;
      end
      if (ctrl.stallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered status is masked while reset is held
  always_comb begin
    stallF      = ctrl.stallF;
    stallD      = ctrl.stallD;
    stallE      = ctrl.stallE;
    flushD      = ctrl.flushD;
    flushE      = ctrl.flushE;
    flushM      = ctrl.flushM;
    mduStart    = start;
    mduError    = error_q & ~reset;
    stallCycles = reset ? '0 : stall_cnt_q;
  end

endmodule
